// File: rtl/rtf64_shift_sched_if.sv
// Bundle of request, shifter and result signals for rtf64_shift_sched.
// slave = the scheduler itself; master = whoever surrounds it.
interface rtf64_shift_sched_if #(
  parameter int WID  = 64,
  parameter int TAGW = 6
);
  // requester 0 (integer pipe)
  logic            r0_valid;
  logic            r0_ready;
  logic [31:0]     r0_ir;
  logic [WID-1:0]  r0_a;
  logic [WID-1:0]  r0_b;
  logic [WID-1:0]  r0_d;
  logic [WID-1:0]  r0_imm;
  logic [31:0]     r0_cds;
  logic [TAGW-1:0] r0_tag;
  // requester 1 (bitfield/address unit)
  logic            r1_valid;
  logic            r1_ready;
  logic [31:0]     r1_ir;
  logic [WID-1:0]  r1_a;
  logic [WID-1:0]  r1_b;
  logic [WID-1:0]  r1_d;
  logic [WID-1:0]  r1_imm;
  logic [31:0]     r1_cds;
  logic [TAGW-1:0] r1_tag;
  // shared shifter datapath
  logic [31:0]     sh_ir;
  logic [WID-1:0]  sh_ia;
  logic [WID-1:0]  sh_ib;
  logic [WID-1:0]  sh_id;
  logic [WID-1:0]  sh_imm;
  logic [31:0]     sh_cds;
  logic [WID-1:0]  sh_res;
  // result
  logic            o_valid;
  logic            o_ready;
  logic [WID-1:0]  o_res;
  logic [TAGW-1:0] o_tag;
  logic            o_src;

  modport slave (
    input  r0_valid, r0_ir, r0_a, r0_b, r0_d, r0_imm, r0_cds, r0_tag,
    output r0_ready,
    input  r1_valid, r1_ir, r1_a, r1_b, r1_d, r1_imm, r1_cds, r1_tag,
    output r1_ready,
    output sh_ir, sh_ia, sh_ib, sh_id, sh_imm, sh_cds,
    input  sh_res,
    output o_valid, o_res, o_tag, o_src,
    input  o_ready
  );

  modport master (
    output r0_valid, r0_ir, r0_a, r0_b, r0_d, r0_imm, r0_cds, r0_tag,
    input  r0_ready,
    output r1_valid, r1_ir, r1_a, r1_b, r1_d, r1_imm, r1_cds, r1_tag,
    input  r1_ready,
    input  sh_ir, sh_ia, sh_ib, sh_id, sh_imm, sh_cds,
    output sh_res,
    input  o_valid, o_res, o_tag, o_src,
    output o_ready
  );
endinterface

// File: rtl/rtf64_shift_sched.sv
// Round-robin scheduler sharing one rtf64_shift datapath between the integer
// pipe (port 0) and the bitfield/address unit (port 1). Two register stages:
// S1 holds the granted operands and drives the shifter, S2 captures the result.
module rtf64_shift_sched #(
  parameter int WID  = 64,
  parameter int TAGW = 6
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  rtf64_shift_sched_if.slave bus
);

  // requester fields gathered into arrays so the winner can be indexed
  logic [1:0]      req_valid;
  logic [31:0]     req_ir   [2];
  logic [WID-1:0]  req_a    [2];
  logic [WID-1:0]  req_b    [2];
  logic [WID-1:0]  req_d    [2];
  logic [WID-1:0]  req_imm  [2];
  logic [31:0]     req_cds  [2];
  logic [TAGW-1:0] req_tag  [2];

  assign req_valid = {bus.r1_valid, bus.r0_valid};
  assign req_ir[0]  = bus.r0_ir;   assign req_ir[1]  = bus.r1_ir;
  assign req_a[0]   = bus.r0_a;    assign req_a[1]   = bus.r1_a;
  assign req_b[0]   = bus.r0_b;    assign req_b[1]   = bus.r1_b;
  assign req_d[0]   = bus.r0_d;    assign req_d[1]   = bus.r1_d;
  assign req_imm[0] = bus.r0_imm;  assign req_imm[1] = bus.r1_imm;
  assign req_cds[0] = bus.r0_cds;  assign req_cds[1] = bus.r1_cds;
  assign req_tag[0] = bus.r0_tag;  assign req_tag[1] = bus.r1_tag;

  // pipeline state
  logic            s1_v_reg;
  logic [31:0]     s1_ir_reg;
  logic [WID-1:0]  s1_a_reg;
  logic [WID-1:0]  s1_b_reg;
  logic [WID-1:0]  s1_d_reg;
  logic [WID-1:0]  s1_imm_reg;
  logic [31:0]     s1_cds_reg;
  logic [TAGW-1:0] s1_tag_reg;
  logic            s1_src_reg;

  logic            s2_v_reg;
  logic [WID-1:0]  s2_res_reg;
  logic [TAGW-1:0] s2_tag_reg;
  logic            s2_src_reg;

  logic            prio_reg;

  logic            s2_en;
  logic            s1_en;
  logic            grant_open;
  logic            win;
  logic [1:0]      grant;
  logic            accept;

  // S2 can take a new value when empty or being drained; S1 when empty or moving on
  assign s2_en = ~s2_v_reg | bus.o_ready;
  assign s1_en = ~s1_v_reg | s2_en;

  // No grants while S1 is stuck, during a flush cycle, or while in reset
  assign grant_open = s1_en & ~flush_i & ~rst_i;

  // Pick the winner: a lone requester wins, a tie goes to prio, idle parks on prio
  always_comb begin
    win = prio_reg;
    if (req_valid[0] & req_valid[1]) win = prio_reg;
    else if (req_valid[1])           win = 1'b1;
    else if (req_valid[0])           win = 1'b0;
  end

  // ready is the grant: only the winning port ever sees it
  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign grant[gi] = grant_open & (win == (gi == 1));
  end

  assign bus.r0_ready = grant[0];
  assign bus.r1_ready = grant[1];
  assign accept       = |(grant & req_valid);

  // S1 register and round-robin pointer; flush kills the op but leaves prio alone
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_v_reg   <= 1'b0;
      s1_ir_reg  <= '0;
      s1_a_reg   <= '0;
      s1_b_reg   <= '0;
      s1_d_reg   <= '0;
      s1_imm_reg <= '0;
      s1_cds_reg <= '0;
      s1_tag_reg <= '0;
      s1_src_reg <= 1'b0;
      prio_reg   <= 1'b0;
    end else if (flush_i) begin
      s1_v_reg <= 1'b0;
    end else if (s1_en) begin
      s1_v_reg <= accept;
      if (accept) begin
        s1_ir_reg  <= req_ir[win];
        s1_a_reg   <= req_a[win];
        s1_b_reg   <= req_b[win];
        s1_d_reg   <= req_d[win];
        s1_imm_reg <= req_imm[win];
        s1_cds_reg <= req_cds[win];
        s1_tag_reg <= req_tag[win];
        s1_src_reg <= win;
        prio_reg   <= ~win;
      end
    end
  end

  // S2 captures the shifter output; data holds when the slot simply drains
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_v_reg   <= 1'b0;
      s2_res_reg <= '0;
      s2_tag_reg <= '0;
      s2_src_reg <= 1'b0;
    end else if (flush_i) begin
      s2_v_reg <= 1'b0;
    end else if (s2_en & s1_v_reg) begin
      s2_v_reg   <= 1'b1;
      s2_res_reg <= bus.sh_res;
      s2_tag_reg <= s1_tag_reg;
      s2_src_reg <= s1_src_reg;
    end else if (bus.o_ready) begin
      s2_v_reg <= 1'b0;
    end
  end

  // shifter operands come straight from S1, so o_ready never reaches them
  assign bus.sh_ir  = s1_ir_reg;
  assign bus.sh_ia  = s1_a_reg;
  assign bus.sh_ib  = s1_b_reg;
  assign bus.sh_id  = s1_d_reg;
  assign bus.sh_imm = s1_imm_reg;
  assign bus.sh_cds = s1_cds_reg;

  assign bus.o_valid = s2_v_reg;
  assign bus.o_res   = s2_res_reg;
  assign bus.o_tag   = s2_tag_reg;
  assign bus.o_src   = s2_src_reg;

endmodule
